// File: rtl/ecc_scrub_ctrl_if.sv
// Memory port of the ECC scrubber: the controller issues single-beat reads and writes,
// and the memory returns read data some cycles later.
interface ecc_scrub_ctrl_if #(
  parameter int ADDR_W = 8
);
  // Handshake: mem_req is a one-cycle strobe with no back-pressure, and mem_we selects
  // write or read. A read completes when mem_rvalid pulses with mem_rdata in any later cycle.
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// Walks the whole memory once per start, checks each word through the shared SECDED decoder,
// writes back corrected single-bit errors and logs uncorrectable words.
module ecc_scrub_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  ecc_scrub_ctrl_if.master  mem,
  output logic [15:0]       dec_codeword,
  input  logic              dec_sed,
  input  logic              dec_ded,
  input  logic [15:0]       dec_corrected,
  output logic [15:0]       sec_count,
  output logic [15:0]       ded_count,
  output logic              ded_seen,
  output logic [ADDR_W-1:0] ded_addr,
  output logic              timeout_err,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] NEXT   = 3'd5;
  localparam logic [2:0] FINISH = 3'd6;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WAIT_W-1:0] wait_q;
  logic [15:0]       word_q;
  logic [15:0]       wr_q;
  logic [15:0]       sec_q;
  logic [15:0]       ded_q;
  logic              seen_q;
  logic [ADDR_W-1:0] daddr_q;
  logic              to_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wait_q  <= '0;
      word_q  <= '0;
      wr_q    <= '0;
      sec_q   <= '0;
      ded_q   <= '0;
      seen_q  <= 1'b0;
      daddr_q <= '0;
      to_q    <= 1'b0;
    end else if (abort && (state_q != IDLE)) begin
      // Abort drops the pass on the spot; counters and flags keep their values.
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= READ;
            addr_q  <= '0;
            sec_q   <= '0;
            ded_q   <= '0;
            seen_q  <= 1'b0;
            daddr_q <= '0;
            to_q    <= 1'b0;
          end
        end
        READ: begin
          wait_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            word_q  <= mem.mem_rdata;
            state_q <= CHECK;
          end else if (wait_q == WAIT_LAST) begin
            to_q    <= 1'b1;
            state_q <= FINISH;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        CHECK: begin
          if (dec_ded) begin
            if (ded_q != 16'hFFFF) ded_q <= ded_q + 16'd1;
            if (!seen_q) begin
              seen_q  <= 1'b1;
              daddr_q <= addr_q;
            end
            state_q <= NEXT;
          end else if (dec_sed) begin
            if (sec_q != 16'hFFFF) sec_q <= sec_q + 16'd1;
            wr_q    <= dec_corrected;
            state_q <= WRITE;
          end else begin
            state_q <= NEXT;
          end
        end
        WRITE: state_q <= NEXT;
        NEXT: begin
          if (addr_q == {ADDR_W{1'b1}}) begin
            state_q <= FINISH;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= READ;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FINISH);
  assign mem.mem_req   = (state_q == READ) || (state_q == WRITE);
  assign mem.mem_we    = (state_q == WRITE);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = (state_q == WRITE) ? wr_q : 16'h0000;
  assign dec_codeword  = word_q;
  assign sec_count     = sec_q;
  assign ded_count     = ded_q;
  assign ded_seen      = seen_q;
  assign ded_addr      = daddr_q;
  assign timeout_err   = to_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Bench for ecc_scrub_ctrl: a 4-word memory with per-address read latency, a stand-in
// decoder keyed on the codeword's top nibble, and a pass-level reference model.
module tb_ecc_scrub_ctrl;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 4;
  localparam int NEVER   = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [15:0]       dec_codeword;
  logic              dec_sed;
  logic              dec_ded;
  logic [15:0]       dec_corrected;
  logic [15:0]       sec_count;
  logic [15:0]       ded_count;
  logic              ded_seen;
  logic [ADDR_W-1:0] ded_addr;
  logic              timeout_err;
  logic [2:0]        state_dbg;

  ecc_scrub_ctrl_if #(.ADDR_W(ADDR_W)) mem_if ();

  ecc_scrub_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .mem(mem_if),
    .dec_codeword(dec_codeword), .dec_sed(dec_sed), .dec_ded(dec_ded),
    .dec_corrected(dec_corrected), .sec_count(sec_count), .ded_count(ded_count),
    .ded_seen(ded_seen), .ded_addr(ded_addr), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Stand-in decoder: top nibble D = uncorrectable (sed follows bit 0), 5 = correctable.
  assign dec_ded       = (dec_codeword[15:12] == 4'hD);
  assign dec_sed       = (dec_codeword[15:12] == 4'h5) || (dec_ded && dec_codeword[0]);
  assign dec_corrected = {4'hA, dec_codeword[11:0]};

  logic [15:0] mem_tab [DEPTH];
  int          lat_tab [DEPTH];

  int vectors     = 0;
  int miscompares = 0;
  int req_cnt     = 0;
  int done_cnt    = 0;
  int proto_err   = 0;

  logic [ADDR_W+15:0] exp_q[$];
  logic [ADDR_W+15:0] obs_w[$];
  logic [ADDR_W-1:0]  exp_r[$];
  logic [ADDR_W-1:0]  obs_r[$];

  int                exp_cyc;
  logic [15:0]       exp_sec;
  logic [15:0]       exp_ded;
  logic              exp_seen;
  logic [ADDR_W-1:0] exp_daddr;
  logic              exp_to;

  // Memory responder and bus monitor.
  initial begin
    int pend;
    logic [ADDR_W-1:0] pend_addr;
    pend = 0;
    pend_addr = '0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = 16'h0;
    forever begin
      @(negedge clk);
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = 16'h0;
      if (rst) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_if.mem_rvalid = 1'b1;
          mem_if.mem_rdata  = mem_tab[pend_addr];
        end
      end
      if (mem_if.mem_req === 1'b1) begin
        req_cnt++;
        if (mem_if.mem_we === 1'b1) begin
          obs_w.push_back({mem_if.mem_addr, mem_if.mem_wdata});
        end else begin
          obs_r.push_back(mem_if.mem_addr);
          pend_addr = mem_if.mem_addr;
          pend = (lat_tab[pend_addr] == NEVER) ? 0 : lat_tab[pend_addr];
        end
      end
      if (done === 1'b1) done_cnt++;
      if (!(mem_if.mem_req && mem_if.mem_we) && (mem_if.mem_wdata !== 16'h0)) proto_err++;
      if ((busy === 1'b0) && ((mem_if.mem_req !== 1'b0) || (done !== 1'b0))) proto_err++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_busy"},   64'(busy), 64'd0);
    check({pfx, "_done"},   64'(done), 64'd0);
    check({pfx, "_req"},    64'(mem_if.mem_req), 64'd0);
    check({pfx, "_we"},     64'(mem_if.mem_we), 64'd0);
    check({pfx, "_addr"},   64'(mem_if.mem_addr), 64'd0);
    check({pfx, "_wdata"},  64'(mem_if.mem_wdata), 64'd0);
    check({pfx, "_cw"},     64'(dec_codeword), 64'd0);
    check({pfx, "_sec"},    64'(sec_count), 64'd0);
    check({pfx, "_ded"},    64'(ded_count), 64'd0);
    check({pfx, "_seen"},   64'(ded_seen), 64'd0);
    check({pfx, "_daddr"},  64'(ded_addr), 64'd0);
    check({pfx, "_tmo"},    64'(timeout_err), 64'd0);
  endtask

  // Pass-level model: cycle cost per word is READ + latency + CHECK (+ WRITE) + NEXT.
  task automatic compute_model();
    exp_q.delete();
    exp_r.delete();
    exp_cyc = 0; exp_sec = 0; exp_ded = 0; exp_seen = 0; exp_daddr = 0; exp_to = 0;
    for (int a = 0; a < DEPTH; a++) begin
      exp_r.push_back(ADDR_W'(a));
      if (lat_tab[a] > TIMEOUT) begin
        exp_cyc += 1 + TIMEOUT;
        exp_to = 1'b1;
        break;
      end
      exp_cyc += 3 + lat_tab[a];
      if (mem_tab[a][15:12] == 4'hD) begin
        exp_ded++;
        if (!exp_seen) begin
          exp_seen  = 1'b1;
          exp_daddr = ADDR_W'(a);
        end
      end else if (mem_tab[a][15:12] == 4'h5) begin
        exp_sec++;
        exp_q.push_back({ADDR_W'(a), 4'hA, mem_tab[a][11:0]});
        exp_cyc++;
      end
    end
  endtask

  task automatic run_pass(input string tag, input int pulse_at);
    int n;
    int dc;
    compute_model();
    repeat (3) @(negedge clk);
    obs_w.delete();
    obs_r.delete();
    proto_err = 0;
    dc = done_cnt;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((done !== 1'b1) && (n < 400)) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == pulse_at);
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 64'(n), 64'(exp_cyc));
    check({tag, "_sec"},  64'(sec_count), 64'(exp_sec));
    check({tag, "_ded"},  64'(ded_count), 64'(exp_ded));
    check({tag, "_seen"}, 64'(ded_seen), 64'(exp_seen));
    check({tag, "_daddr"}, 64'(ded_addr), 64'(exp_daddr));
    check({tag, "_tmo"},  64'(timeout_err), 64'(exp_to));
    check({tag, "_nwr"},  64'(obs_w.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_w.size(); i++)
      check({tag, "_wr"}, 64'(obs_w[i]), 64'(exp_q[i]));
    check({tag, "_nrd"},  64'(obs_r.size()), 64'(exp_r.size()));
    for (int i = 0; i < exp_r.size() && i < obs_r.size(); i++)
      check({tag, "_rd_addr"}, 64'(obs_r[i]), 64'(exp_r[i]));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_width"}, 64'(done), 64'd0);
    check({tag, "_done_pulses"}, 64'(done_cnt - dc), 64'd1);
    check({tag, "_protocol"}, 64'(proto_err), 64'd0);
  endtask

  function automatic logic [15:0] rand_word();
    int k;
    logic [3:0] top;
    k = $urandom_range(0, 9);
    top = 4'($urandom_range(0, 15));
    if (k < 2) return {4'h5, 12'($urandom)};
    if (k == 2) return {4'hD, 12'($urandom)};
    if (top == 4'h5 || top == 4'hD) top = 4'h0;
    return {top, 12'($urandom)};
  endfunction

  initial begin
    int rc;
    int dc;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      mem_tab[a] = 16'h0100 + 16'(a);
      lat_tab[a] = 1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // All clean, one-cycle latency.
    run_pass("clean", 0);

    // Correctable word at address 2.
    mem_tab[2] = 16'h55A5;
    run_pass("sec_addr2", 0);

    // Uncorrectable words at addresses 1 and 3 (one with sed also set).
    mem_tab[2] = 16'h0102;
    mem_tab[1] = 16'hD001;
    mem_tab[3] = 16'hD340;
    run_pass("ded_1_3", 0);

    // Read data never returns at address 0.
    for (int a = 0; a < DEPTH; a++) mem_tab[a] = 16'h0200 + 16'(a);
    lat_tab[0] = NEVER;
    run_pass("timeout", 0);

    // Latency boundary: last allowed WAIT cycle, then one beyond.
    lat_tab[0] = TIMEOUT;
    run_pass("lat_max", 5);
    lat_tab[0] = TIMEOUT + 1;
    run_pass("lat_over", 5);
    repeat (4) @(negedge clk);

    // Abort while waiting on the read of address 1.
    mem_tab[0] = 16'h5123;
    lat_tab[0] = 1; lat_tab[1] = 6; lat_tab[2] = 1; lat_tab[3] = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_at_addr", 64'(mem_if.mem_addr), 64'd1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    rc = req_cnt;
    dc = done_cnt;
    check("abort_busy", 64'(busy), 64'd0);
    repeat (12) @(negedge clk);
    check("abort_no_req", 64'(req_cnt), 64'(rc));
    check("abort_no_done", 64'(done_cnt), 64'(dc));
    check("abort_sec_hold", 64'(sec_count), 64'd1);
    mem_tab[0] = 16'h0300;
    lat_tab[1] = 1;
    run_pass("after_abort", 0);

    // Reset while in WRITE, with start held alongside it.
    mem_tab[0] = 16'h5777;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("write_cycle_we", 64'(mem_if.mem_we), 64'd1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("rst_in_write");
    rst = 1'b0;
    start = 1'b0;

    // Randomized passes with spurious start pulses mid-pass.
    for (int p = 0; p < 10; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_tab[a] = rand_word();
        lat_tab[a] = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(1, 4);
      end
      run_pass($sformatf("rand%0d", p), $urandom_range(2, 12));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of memory address (scrub range is 0..2^ADDR_W-1).
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum cycles waited for read data before a timeout error.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a full scrub pass.
REQ-006 SHALL have port abort  input  1  terminates an active pass.
REQ-007 SHALL have port busy  output  1  high while a pass is active.
REQ-008 SHALL have port done  output  1  one-cycle pulse at normal or timeout pass end.
REQ-009 SHALL have port mem_req  output  1  memory access strobe, one cycle per access.
REQ-010 SHALL have port mem_we  output  1  write enable, qualified by mem_req.
REQ-011 SHALL have port mem_addr  output  ADDR_W  access address.
REQ-012 SHALL have port mem_wdata  output  16  corrected codeword for writeback.
REQ-013 SHALL have port mem_rdata  input  16  read codeword, valid when mem_rvalid.
REQ-014 SHALL have port mem_rvalid  input  1  read data valid, any cycle after the read strobe.
REQ-015 SHALL have port dec_codeword  output  16  codeword driven to the shared combinational SECDED decoder.
REQ-016 SHALL have ports dec_sed  input  1, dec_ded  input  1, dec_corrected  input  16  decoder results, same cycle as dec_codeword.
REQ-017 SHALL have ports sec_count  output  16, ded_count  output  16  error counts for the current/last pass.
REQ-018 SHALL have ports ded_seen  output  1, ded_addr  output  ADDR_W  sticky flag and address of first uncorrectable word.
REQ-019 SHALL have port timeout_err  output  1  sticky flag set when read data never arrives.

Function
REQ-020 SHALL implement states IDLE, READ, WAIT, CHECK, WRITE, NEXT, FINISH.
REQ-021 IDLE: start=1 -> READ next cycle; address counter, sec_count, ded_count, ded_seen, ded_addr, timeout_err cleared on that edge.
REQ-022 READ: mem_req=1, mem_we=0, mem_addr=address counter for exactly one cycle -> WAIT.
REQ-023 WAIT: on mem_rvalid capture mem_rdata into word register -> CHECK; mem_rvalid in the READ cycle itself is ignored.
REQ-024 WAIT: wait counter increments per cycle without mem_rvalid; after TIMEOUT such cycles set timeout_err -> FINISH.
REQ-025 CHECK (one cycle): dec_codeword = word register (dec_codeword = word register in all states).
REQ-026 CHECK: dec_ded=1 (regardless of dec_sed) -> ded_count+1; if ded_seen=0 set ded_seen and ded_addr=address; -> NEXT, no writeback.
REQ-027 CHECK: dec_sed=1 and dec_ded=0 -> sec_count+1, latch dec_corrected into write register -> WRITE.
REQ-028 CHECK: both 0 -> NEXT.
REQ-029 WRITE: mem_req=1, mem_we=1, mem_addr=address, mem_wdata=write register, one cycle -> NEXT.
REQ-030 NEXT: address = 2^ADDR_W-1 -> FINISH; else address+1 -> READ; address never wraps within a pass.
REQ-031 FINISH: done=1 for one cycle -> IDLE.
REQ-032 busy=1 in every state except IDLE.
REQ-033 Counters saturate at 16'hFFFF.
REQ-034 start while busy SHALL be ignored.
REQ-035 abort=1 in any non-IDLE state -> IDLE next cycle, no done pulse, no further mem_req; counters/flags hold; abort has priority over all transitions.
REQ-036 mem_req SHALL be 0 in IDLE, WAIT, CHECK, NEXT, FINISH; mem_wdata=0 when not writing.
REQ-037 Read-to-next-read for a clean word with 1-cycle memory latency: READ, WAIT, CHECK, NEXT = 4 cycles; corrected word adds 1 (WRITE).

Reset
REQ-038 rst=1 at a clock edge SHALL force IDLE from any state, including mid-pass, taking priority over start and abort.
REQ-039 Reset values: busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dec_codeword=0, sec_count=0, ded_count=0, ded_seen=0, ded_addr=0, timeout_err=0.

Verification
REQ-040 ADDR_W=2, all four words clean, rvalid 1 cycle after req -> 4 reads, 0 writes, done 16 cycles after start, sec_count=0, ded_count=0.
REQ-041 Word at addr 2 single-bit error (decoder sed=1, corrected=16'hA5A5) -> one write to addr 2 with wdata 16'hA5A5 immediately after CHECK, sec_count=1.
REQ-042 Addr 1 and 3 double errors -> no writes, ded_count=2, ded_seen=1, ded_addr=1.
REQ-043 mem_rvalid never asserted at addr 0, TIMEOUT=15 -> timeout_err=1, done pulse after 15 WAIT cycles, busy=0 next cycle.
REQ-044 abort during WAIT at addr 1 -> IDLE next cycle, no done, no mem_req; subsequent start clears counters and scrubs from addr 0.
REQ-045 rst asserted in WRITE -> next cycle all outputs at reset values; start during busy never restarts the pass.
